// File: rtl/fifo_read_seq_if.sv
// Handshake bundle between fifo_read_seq and its command source, FIFO buffer and PE array.
// slave is the sequencer's view; master is the view of everything around it.
interface fifo_read_seq_if #(
  parameter int Size   = 12,
  parameter int DWd    = 16,
  parameter int InsNum = 16,
  parameter int RepWd  = 4,
  parameter int AWd    = $clog2(Size)
);
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic [AWd-1:0]        i_cmd_len;
  logic [RepWd-1:0]      i_cmd_rep;
  logic [AWd-1:0]        i_cmd_pop;
  logic [AWd:0]          i_fifo_count;
  logic                  o_fifo_read;
  logic [AWd-1:0]        o_fifo_raddr;
  logic                  o_fifo_pop;
  logic                  o_fifo_lastpix;
  logic [InsNum*DWd-1:0] i_fifo_rdata;
  logic                  i_fifo_rvalid;
  logic [InsNum*DWd-1:0] o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_last;
  logic                  o_done;

  modport slave (
    input  i_cmd_valid, i_cmd_len, i_cmd_rep, i_cmd_pop, i_fifo_count,
           i_fifo_rdata, i_fifo_rvalid, i_ready,
    output o_cmd_ready, o_fifo_read, o_fifo_raddr, o_fifo_pop, o_fifo_lastpix,
           o_data, o_valid, o_last, o_done
  );

  modport master (
    output i_cmd_valid, i_cmd_len, i_cmd_rep, i_cmd_pop, i_fifo_count,
           i_fifo_rdata, i_fifo_rvalid, i_ready,
    input  o_cmd_ready, o_fifo_read, o_fifo_raddr, o_fifo_pop, o_fifo_lastpix,
           o_data, o_valid, o_last, o_done
  );
endinterface

// File: rtl/fifo_read_seq.sv
// Read-side sequencer: replays a window of FIFO entries rep times into a 2-entry skid buffer,
// then pops. Optional stall counter output o_stall_cnt is enabled by FIFORDSEQ_PERF_EN.
module fifo_read_seq #(
  parameter int Size   = 12,
  parameter int DWd    = 16,
  parameter int InsNum = 16,
  parameter int RepWd  = 4,
  parameter int AWd    = $clog2(Size)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fifo_read_seq_if.slave    bus
`ifdef FIFORDSEQ_PERF_EN
  ,
  output logic [15:0]       o_stall_cnt
`endif
);
  localparam int DatW = InsNum * DWd;
  localparam logic [AWd:0] SizeW = Size[AWd:0];

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_DRAIN, S_POP, S_DONE} state_e;

  function automatic logic [AWd-1:0] wrap_add(input logic [AWd-1:0] a, input logic [AWd-1:0] b);
    logic [AWd:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= SizeW) s = s - SizeW;
    return s[AWd-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [AWd-1:0]   len_q, len_d, pop_len_q, pop_len_d, base_q, base_d;
  logic [AWd-1:0]   idx_q, idx_d, pop_cnt_q, pop_cnt_d;
  logic [RepWd-1:0] rep_q, rep_d, pass_q, pass_d;
  logic             infl_q, infl_d, infl_last_q, infl_last_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             head_q, head_d, tail_q, tail_d;
  logic [DatW-1:0]  mem_q [2];
  logic             mem_last_q [2];

  logic             rd, lastpix, pop, done, take, push, room, end_pass, final_pass, valid;
  logic [2:0]       occ;

  assign valid      = (cnt_q != 2'd0);
  assign take       = valid && bus.i_ready;
  // Late returns from reads issued before a reset have no in-flight slot and are dropped.
  assign push       = bus.i_fifo_rvalid && infl_q;
  assign occ        = {1'b0, cnt_q} - {2'b00, take} + {2'b00, infl_q};
  assign room       = (occ < 3'd2);
  assign end_pass   = (idx_q == len_q - AWd'(1));
  assign final_pass = (pass_q == rep_q - RepWd'(1));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rep_d     = rep_q;
    pop_len_d = pop_len_q;
    base_d    = base_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    pop_cnt_d = pop_cnt_q;
    rd        = 1'b0;
    lastpix   = 1'b0;
    pop       = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_cmd_valid) begin
          len_d     = bus.i_cmd_len;
          rep_d     = (bus.i_cmd_rep == '0) ? RepWd'(1) : bus.i_cmd_rep;
          pop_len_d = bus.i_cmd_pop;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        idx_d  = '0;
        pass_d = '0;
        if (bus.i_fifo_count >= {1'b0, len_q}) state_d = S_READ;
      end
      S_READ: begin
        if (room) begin
          rd = 1'b1;
          if (end_pass) begin
            lastpix = 1'b1;
            idx_d   = '0;
            if (final_pass) state_d = S_DRAIN;
            else            pass_d  = pass_q + RepWd'(1);
          end else begin
            idx_d = idx_q + AWd'(1);
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == 2'd0 && !infl_q) begin
          pop_cnt_d = '0;
          state_d   = (pop_len_q == '0) ? S_DONE : S_POP;
        end
      end
      S_POP: begin
        pop       = 1'b1;
        base_d    = wrap_add(base_q, AWd'(1));
        pop_cnt_d = pop_cnt_q + AWd'(1);
        if (pop_cnt_q == pop_len_q - AWd'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    infl_d      = rd;
    infl_last_d = rd && end_pass && final_pass;
    cnt_d       = cnt_q + {1'b0, push} - {1'b0, take};
    head_d      = take ? ~head_q : head_q;
    tail_d      = push ? ~tail_q : tail_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      rep_q       <= '0;
      pop_len_q   <= '0;
      base_q      <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      pop_cnt_q   <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= '0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rep_q       <= rep_d;
      pop_len_q   <= pop_len_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      pop_cnt_q   <= pop_cnt_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  // Skid buffer storage: read data lands here one cycle after the strobe.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[tail_q]      <= bus.i_fifo_rdata;
      mem_last_q[tail_q] <= infl_last_q;
    end
  end

  assign bus.o_cmd_ready    = (state_q == S_IDLE);
  assign bus.o_fifo_read    = rd;
  assign bus.o_fifo_raddr   = wrap_add(base_q, idx_q);
  assign bus.o_fifo_pop     = pop;
  assign bus.o_fifo_lastpix = lastpix;
  assign bus.o_valid        = valid;
  assign bus.o_data         = valid ? mem_q[head_q] : '0;
  assign bus.o_last         = valid && mem_last_q[head_q];
  assign bus.o_done         = done;

`ifdef FIFORDSEQ_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && bus.i_cmd_valid)
      stall_d = '0;
    else if (((valid && !bus.i_ready) || state_q == S_WAIT) && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign o_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_fifo_read_seq.sv
// Bench for fifo_read_seq: a queue-based model of the expected read/beat streams checked every cycle,
// plus literal address/beat expectations for each directed command.
module tb_fifo_read_seq;
  localparam int Size = 12, DWd = 16, InsNum = 16, RepWd = 4, AWd = $clog2(Size);
  localparam int W = InsNum * DWd;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_read_seq_if #(.Size(Size), .DWd(DWd), .InsNum(InsNum), .RepWd(RepWd)) bus ();

`ifdef FIFORDSEQ_PERF_EN
  logic [15:0] stall_cnt;
`endif

  fifo_read_seq #(.Size(Size), .DWd(DWd), .InsNum(InsNum), .RepWd(RepWd)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef FIFORDSEQ_PERF_EN
    ,
    .o_stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] word(input int a);
    logic [W-1:0] w;
    for (int l = 0; l < InsNum; l++) w[l*DWd +: DWd] = DWd'(32'hA000 + a * 16 + l);
    return w;
  endfunction

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // FIFO buffer stand-in: 1-cycle read latency, junk on the data bus when not valid.
  logic         rv_r = 1'b0;
  logic [W-1:0] rd_r;
  always @(posedge clk) begin
    rv_r <= bus.o_fifo_read;
    rd_r <= word(int'(bus.o_fifo_raddr));
  end
  assign bus.i_fifo_rvalid = rv_r;
  assign bus.i_fifo_rdata  = rv_r ? rd_r : '1;

  typedef struct {int a; bit lp;} rd_t;
  typedef struct {logic [W-1:0] d; bit last;} bt_t;

  rd_t rq[$];
  bt_t bq[$];
  int  raddr_log[$], lp_log[$], last_log[$];
  int  cyc = 0, reads = 0, returns = 0, takes = 0, pops_seen = 0, exp_pop = 0;
  int  base_m = 0, len_m = 0, due = -1, done_seen = 0, last_pops = 0, rp = 0, a = 0;
  bit  busy = 0, waiting = 0, prev_stall = 0, tk = 0;
  rd_t r;
  bt_t b;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_cmd_ready", bus.o_cmd_ready, 1);
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_read", bus.o_fifo_read, 0);
      chk("rst_pop", bus.o_fifo_pop, 0);
      chk("rst_lastpix", bus.o_fifo_lastpix, 0);
      chk("rst_done", bus.o_done, 0);
      chk("rst_last", bus.o_last, 0);
      chk("rst_data", bus.o_data, 0);
`ifdef FIFORDSEQ_PERF_EN
      chk("rst_stall_cnt", stall_cnt, 0);
`endif
      rq.delete(); bq.delete();
      busy = 0; waiting = 0; due = -1; prev_stall = 0;
      reads = 0; returns = 0; takes = 0; pops_seen = 0; base_m = 0;
    end else begin
      tk = bus.o_valid && bus.i_ready;
      chk("cmd_ready", bus.o_cmd_ready, !busy);
      if (bus.o_fifo_read) begin
        if (rq.size() == 0) chk("read_unexpected", 1, 0);
        else begin
          r = rq.pop_front();
          chk("raddr", bus.o_fifo_raddr, r.a);
          chk("lastpix", bus.o_fifo_lastpix, r.lp);
          raddr_log.push_back(int'(bus.o_fifo_raddr));
          if (bus.o_fifo_lastpix) lp_log.push_back(raddr_log.size() - 1);
        end
        if (waiting) begin
          chk("first_read_cycle", cyc, due);
          waiting = 0;
        end
      end else begin
        chk("lastpix_idle", bus.o_fifo_lastpix, 0);
        if (waiting && due == cyc) chk("first_read_missing", 0, 1);
      end
      if (waiting && due < 0 && int'(bus.i_fifo_count) >= len_m) due = cyc + 1;
      if (bus.i_fifo_rvalid && (reads - returns) > 0) begin
        chk("rvalid_into_full", (returns - takes - int'(tk)) <= 1, 1);
        returns++;
      end
      if (bus.o_valid) begin
        if (bq.size() == 0) chk("valid_unexpected", 1, 0);
        else begin
          chk("data", bus.o_data, bq[0].d);
          chk("last", bus.o_last, bq[0].last);
          if (tk) begin
            last_log.push_back(int'(bq[0].last));
            void'(bq.pop_front());
            takes++;
          end
        end
      end else if (prev_stall) begin
        chk("valid_dropped_in_stall", 0, 1);
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      if (bus.o_fifo_read) reads++;
      chk("occupancy_le_2", (reads - takes) <= 2, 1);
      if (bus.o_fifo_pop) begin
        pops_seen++;
        chk("pop_while_busy", busy, 1);
        chk("pop_after_drain", (rq.size() == 0 && bq.size() == 0 && reads == takes), 1);
        chk("pop_with_lastpix", bus.o_fifo_lastpix, 0);
      end
      if (bus.o_done) begin
        chk("done_busy", busy, 1);
        chk("done_pops", pops_seen, exp_pop);
        chk("done_beats_left", bq.size(), 0);
        last_pops = pops_seen;
        base_m = (base_m + exp_pop) % Size;
        busy = 0;
        done_seen++;
      end
      if (bus.i_cmd_valid && bus.o_cmd_ready) begin
        rp = (bus.i_cmd_rep == 0) ? 1 : int'(bus.i_cmd_rep);
        len_m = int'(bus.i_cmd_len);
        exp_pop = int'(bus.i_cmd_pop);
        for (int p = 0; p < rp; p++) begin
          for (int i = 0; i < len_m; i++) begin
            a = (base_m + i) % Size;
            r.a = a;
            r.lp = (i == len_m - 1);
            rq.push_back(r);
            b.d = word(a);
            b.last = (p == rp - 1) && (i == len_m - 1);
            bq.push_back(b);
          end
        end
        busy = 1; waiting = 1; due = -1; pops_seen = 0;
      end
    end
  end

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic clear_logs();
    raddr_log.delete(); lp_log.delete(); last_log.delete();
  endtask

  task automatic run_cmd(input int len, input int rep, input int pop, input int cnt);
    @(posedge clk); #1;
    bus.i_fifo_count = (AWd+1)'(cnt);
    bus.i_cmd_len    = AWd'(len);
    bus.i_cmd_rep    = RepWd'(rep);
    bus.i_cmd_pop    = AWd'(pop);
    bus.i_cmd_valid  = 1'b1;
    @(posedge clk); #1;
    bus.i_cmd_valid  = 1'b0;
  endtask

  task automatic wait_done(input bit toggle, input int budget);
    int  start;
    bit  seen;
    start = done_seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      if (done_seen > start) begin
        seen = 1;
        break;
      end
      #1 bus.i_ready = toggle ? pat[k % 4] : 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    #1 bus.i_ready = 1'b1;
  endtask

  int exp_t1 [6] = '{0, 1, 2, 0, 1, 2};
  int exp_t2 [4] = '{10, 11, 0, 1};
  int exp_t4 [5] = '{10, 11, 0, 1, 2};

  initial begin
    bus.i_cmd_valid = 1'b0; bus.i_cmd_len = '0; bus.i_cmd_rep = '0; bus.i_cmd_pop = '0;
    bus.i_fifo_count = '0; bus.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // len=3 rep=2 pop=1 from base 0
    clear_logs(); run_cmd(3, 2, 1, 3); wait_done(0, 300);
    chk("t1_reads", raddr_log.size(), 6);
    for (int i = 0; i < 6; i++) chk("t1_raddr", qat(raddr_log, i), exp_t1[i]);
    chk("t1_lastpix_cnt", lp_log.size(), 2);
    chk("t1_lastpix_read3", qat(lp_log, 0), 2);
    chk("t1_lastpix_read6", qat(lp_log, 1), 5);
    chk("t1_beats", last_log.size(), 6);
    chk("t1_last_beat6", qat(last_log, 5), 1);
    chk("t1_no_early_last", qat(last_log, 2), 0);
    chk("t1_pops", last_pops, 1);

    // advance base from 1 to 10
    clear_logs(); run_cmd(9, 1, 9, 12); wait_done(0, 300);
    chk("t1b_starts_base1", qat(raddr_log, 0), 1);
    chk("t1b_pops", last_pops, 9);

    // wrap from base 10
    clear_logs(); run_cmd(4, 1, 0, 12); wait_done(0, 300);
    for (int i = 0; i < 4; i++) chk("t2_raddr", qat(raddr_log, i), exp_t2[i]);
    chk("t2_beats", last_log.size(), 4);

    // WAIT holds until count reaches len
    clear_logs(); run_cmd(4, 1, 0, 2);
    repeat (6) @(posedge clk);
    chk("t3_no_read_in_wait", raddr_log.size(), 0);
    #1 bus.i_fifo_count = 5'd4;
    wait_done(0, 300);
    chk("t3_reads", raddr_log.size(), 4);

    // backpressure pattern, count dropped mid-read
    clear_logs(); run_cmd(5, 1, 2, 12);
    for (int k = 0; k < 20 && raddr_log.size() == 0; k++) @(posedge clk);
    #1 bus.i_fifo_count = '0;
    wait_done(1, 300);
    for (int i = 0; i < 5; i++) chk("t4_raddr", qat(raddr_log, i), exp_t4[i]);
    chk("t4_beats", last_log.size(), 5);
    chk("t4_last_beat5", qat(last_log, 4), 1);

    // reset mid-pass, then a short command
    clear_logs(); run_cmd(6, 3, 3, 12);
    for (int k = 0; k < 50 && raddr_log.size() < 4; k++) @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("t5_ready_after_rst", bus.o_cmd_ready, 1);
    chk("t5_valid_after_rst", bus.o_valid, 0);
    clear_logs(); run_cmd(2, 1, 0, 12); wait_done(0, 300);
    chk("t5_raddr0", qat(raddr_log, 0), 0);
    chk("t5_raddr1", qat(raddr_log, 1), 1);
    chk("t5_beats", last_log.size(), 2);
    chk("t5_last_beat2", qat(last_log, 1), 1);

    // single beat, then a full-ring window with rep=0
    clear_logs(); run_cmd(1, 1, 1, 12); wait_done(0, 300);
    chk("t6_single_beats", last_log.size(), 1);
    chk("t6_single_last", qat(last_log, 0), 1);
    chk("t6_single_raddr", qat(raddr_log, 0), 0);
    clear_logs(); run_cmd(12, 0, 0, 12); wait_done(0, 300);
    chk("t6_ring_reads", raddr_log.size(), 12);
    chk("t6_ring_first", qat(raddr_log, 0), 1);
    chk("t6_ring_wrap11", qat(raddr_log, 10), 11);
    chk("t6_ring_wrap0", qat(raddr_log, 11), 0);
    chk("t6_ring_last", qat(last_log, 11), 1);

`ifdef FIFORDSEQ_PERF_EN
    begin
      int c0;
      clear_logs();
      bus.i_ready = 1'b0;
      run_cmd(2, 1, 0, 12);
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (bus.o_valid) break;
      end
      c0 = int'(stall_cnt);
      chk("perf_wait_cycle", c0, 1);
      repeat (7) @(negedge clk);
      chk("perf_stall_7", int'(stall_cnt) - c0, 7);
      wait_done(0, 300);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
